// File: rtl/stim_sequencer_if.sv
// Signal bundle between the stimulus sequencer, its stimulus RAM and the DUT it drives.
// master = sequencer side, slave = environment side (control, RAM, DUT).
interface stim_sequencer_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 5
);
  logic              start;
  logic              loop;
  logic [ADDR_W-1:0] last_addr;
  logic              stop;
  logic              hold;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  // stim_valid qualifies stim_out; hold=1 at an edge freezes the applied word,
  // and a word counts as applied only at an edge where it is loaded with hold=0.
  logic [DATA_W-1:0] stim_out;
  logic              stim_valid;
  logic              obs;
  logic              busy;
  logic              done;
  logic [15:0]       applied_cnt;
  logic [1:0]        dbg_state;

  modport master (
    input  start, loop, last_addr, stop, hold, mem_rdata,
    output mem_rd_en, mem_addr, stim_out, stim_valid, obs, busy, done,
           applied_cnt, dbg_state
  );

  modport slave (
    output start, loop, last_addr, stop, hold, mem_rdata,
    input  mem_rd_en, mem_addr, stim_out, stim_valid, obs, busy, done,
           applied_cnt, dbg_state
  );
endinterface

// File: rtl/stim_sequencer.sv
// Plays opcode words from a synchronous-read stimulus RAM onto a DUT input bus,
// one word per clock, with hold back-pressure, stop abort and optional looping.
module stim_sequencer #(
  parameter int DATA_W  = 12,
  parameter int ADDR_W  = 5,
  parameter int OBS_BIT = 11
) (
  input logic               clock,
  input logic               reset,
  stim_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;

  logic              loop_q;
  logic [ADDR_W-1:0] last_q;
  logic [ADDR_W-1:0] ptr;
  logic              inflight;
  logic [DATA_W-1:0] skid [2];
  logic [1:0]        skid_cnt;
  logic [DATA_W-1:0] stim_out;
  logic              stim_valid;
  logic              done;
  logic [15:0]       applied_cnt;

  logic              rd_en;
  logic              done_next;
  logic              start_run;
  logic              stop_run;
  logic [1:0]        buffered;

  // Words already committed: the read returning this cycle plus skid entries.
  assign buffered = skid_cnt + {1'b0, inflight};

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    done_next  = 1'b0;
    start_run  = 1'b0;
    stop_run   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = RUN;
          start_run  = 1'b1;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_next = IDLE;
          stop_run   = 1'b1;
        end else begin
          rd_en = !bus.hold || (buffered < 2'd2);
          if (rd_en && (ptr == last_q) && !loop_q) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (bus.stop) begin
          state_next = IDLE;
          stop_run   = 1'b1;
        end else if (!inflight && (skid_cnt == 2'd0) && !bus.hold) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      loop_q      <= 1'b0;
      last_q      <= '0;
      ptr         <= '0;
      inflight    <= 1'b0;
      skid[0]     <= '0;
      skid[1]     <= '0;
      skid_cnt    <= 2'd0;
      stim_out    <= '0;
      stim_valid  <= 1'b0;
      done        <= 1'b0;
      applied_cnt <= 16'd0;
    end else begin
      done <= done_next;
      if (start_run) begin
        loop_q      <= bus.loop;
        last_q      <= bus.last_addr;
        ptr         <= '0;
        applied_cnt <= 16'd0;
      end
      if (stop_run) begin
        inflight   <= 1'b0;
        skid_cnt   <= 2'd0;
        stim_valid <= 1'b0;
        stim_out   <= '0;
      end else begin
        inflight <= rd_en;
        if (rd_en) begin
          ptr <= (ptr == last_q) ? '0 : ptr + ADDR_W'(1);
        end
        if (!bus.hold) begin
          if (skid_cnt != 2'd0) begin
            stim_out    <= skid[0];
            stim_valid  <= 1'b1;
            applied_cnt <= applied_cnt + 16'd1;
            skid[0]     <= skid[1];
            // Later assignment wins when the returning word lands in slot 0.
            if (inflight) begin
              skid[skid_cnt[1]] <= bus.mem_rdata;
            end
            skid_cnt <= skid_cnt - 2'd1 + {1'b0, inflight};
          end else if (inflight) begin
            stim_out    <= bus.mem_rdata;
            stim_valid  <= 1'b1;
            applied_cnt <= applied_cnt + 16'd1;
          end else begin
            stim_valid <= 1'b0;
          end
        end else if (inflight) begin
          skid[skid_cnt[0]] <= bus.mem_rdata;
          skid_cnt          <= skid_cnt + 2'd1;
        end
      end
    end
  end

  assign bus.mem_rd_en   = rd_en;
  assign bus.mem_addr    = (state == RUN) ? ptr : '0;
  assign bus.stim_out    = stim_out;
  assign bus.stim_valid  = stim_valid;
  assign bus.obs         = stim_valid & stim_out[OBS_BIT];
  assign bus.busy        = (state != IDLE);
  assign bus.done        = done;
  assign bus.applied_cnt = applied_cnt;
  assign bus.dbg_state   = state;

endmodule

// File: tb/tb_stim_sequencer.sv
// Directed table-driven bench for stim_sequencer: one row per clock cycle of inputs
// and hand-computed outputs, plus hand-written reset checks.
module tb_stim_sequencer;

  logic clk;
  logic rst;

  stim_sequencer_if #(.DATA_W(12), .ADDR_W(5)) bus ();

  stim_sequencer #(.DATA_W(12), .ADDR_W(5), .OBS_BIT(11)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [11:0] ram [32];

  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= ram[bus.mem_addr];
  end

  typedef struct packed {
    logic        start;
    logic        stop;
    logic        hold;
    logic [11:0] out;
    logic        valid;
    logic        busy;
    logic        done;
    logic        rd;
    logic [4:0]  addr;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [64];
  int   n_rows;
  int   checks;
  int   failures;

  function automatic vec_t mk(input logic s, input logic p, input logic h,
                              input logic [11:0] o, input logic v, input logic b,
                              input logic d, input logic r, input logic [4:0] a,
                              input logic [15:0] c);
    vec_t x;
    x.start = s; x.stop = p; x.hold = h; x.out = o; x.valid = v;
    x.busy = b; x.done = d; x.rd = r; x.addr = a; x.cnt = c;
    return x;
  endfunction

  task automatic add(input vec_t v);
    tbl[n_rows] = v;
    n_rows++;
  endtask

  task automatic check(input string name, input int row, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic check_outs(input int row, input vec_t e);
    check("stim_out",    row, {4'd0, bus.stim_out},  {4'd0, e.out});
    check("stim_valid",  row, {15'd0, bus.stim_valid}, {15'd0, e.valid});
    check("obs",         row, {15'd0, bus.obs},      {15'd0, e.valid & e.out[11]});
    check("busy",        row, {15'd0, bus.busy},     {15'd0, e.busy});
    check("done",        row, {15'd0, bus.done},     {15'd0, e.done});
    check("mem_rd_en",   row, {15'd0, bus.mem_rd_en}, {15'd0, e.rd});
    check("mem_addr",    row, {11'd0, bus.mem_addr}, {11'd0, e.addr});
    check("applied_cnt", row, bus.applied_cnt,       e.cnt);
  endtask

  // Entered just after a rising edge; each row is one cycle.
  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus.start = tbl[i].start;
      bus.stop  = tbl[i].stop;
      bus.hold  = tbl[i].hold;
      @(negedge clk);
      check_outs(i, tbl[i]);
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.hold  = 1'b0;
  endtask

  task automatic load_ram_a();
    for (int i = 0; i < 32; i++) ram[i] = 12'h000;
    ram[0] = 12'h801; ram[1] = 12'h002; ram[2] = 12'h004; ram[3] = 12'h808;
    ram[4] = 12'h040; ram[5] = 12'h880;
  endtask

  int a_lo, b_lo, c_lo, d_lo, e_lo;

  initial begin
    checks = 0; failures = 0; n_rows = 0;
    rst = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.hold = 1'b0;
    bus.loop = 1'b0; bus.last_addr = 5'd0; bus.mem_rdata = 12'h000;
    load_ram_a();

    // A: plain playback, last_addr=3
    a_lo = n_rows;
    add(mk(1,0,0, 12'h000,0,0,0,0,5'd0,16'd0));
    add(mk(0,0,0, 12'h000,0,1,0,1,5'd0,16'd0));
    add(mk(0,0,0, 12'h000,0,1,0,1,5'd1,16'd0));
    add(mk(0,0,0, 12'h801,1,1,0,1,5'd2,16'd1));
    add(mk(0,0,0, 12'h002,1,1,0,1,5'd3,16'd2));
    add(mk(0,0,0, 12'h004,1,1,0,0,5'd0,16'd3));
    add(mk(0,0,0, 12'h808,1,1,0,0,5'd0,16'd4));
    add(mk(0,0,0, 12'h808,0,0,1,0,5'd0,16'd4));
    add(mk(0,0,0, 12'h808,0,0,0,0,5'd0,16'd4));
    // B: hold during E+4..E+6
    b_lo = n_rows;
    add(mk(1,0,0, 12'h808,0,0,0,0,5'd0,16'd4));
    add(mk(0,0,0, 12'h808,0,1,0,1,5'd0,16'd0));
    add(mk(0,0,0, 12'h808,0,1,0,1,5'd1,16'd0));
    add(mk(0,0,0, 12'h801,1,1,0,1,5'd2,16'd1));
    add(mk(0,0,1, 12'h002,1,1,0,1,5'd3,16'd2));
    add(mk(0,0,1, 12'h002,1,1,0,0,5'd0,16'd2));
    add(mk(0,0,1, 12'h002,1,1,0,0,5'd0,16'd2));
    add(mk(0,0,0, 12'h002,1,1,0,0,5'd0,16'd2));
    add(mk(0,0,0, 12'h004,1,1,0,0,5'd0,16'd3));
    add(mk(0,0,0, 12'h808,1,1,0,0,5'd0,16'd4));
    add(mk(0,0,0, 12'h808,0,0,1,0,5'd0,16'd4));
    add(mk(0,0,0, 12'h808,0,0,0,0,5'd0,16'd4));
    // C: last_addr=5, hold during E+3..E+6 fills the skid and stalls reads
    c_lo = n_rows;
    add(mk(1,0,0, 12'h808,0,0,0,0,5'd0,16'd4));
    add(mk(0,0,0, 12'h808,0,1,0,1,5'd0,16'd0));
    add(mk(0,0,0, 12'h808,0,1,0,1,5'd1,16'd0));
    add(mk(0,0,1, 12'h801,1,1,0,1,5'd2,16'd1));
    add(mk(0,0,1, 12'h801,1,1,0,0,5'd3,16'd1));
    add(mk(0,0,1, 12'h801,1,1,0,0,5'd3,16'd1));
    add(mk(0,0,1, 12'h801,1,1,0,0,5'd3,16'd1));
    add(mk(0,0,0, 12'h801,1,1,0,1,5'd3,16'd1));
    add(mk(0,0,0, 12'h002,1,1,0,1,5'd4,16'd2));
    add(mk(0,0,0, 12'h004,1,1,0,1,5'd5,16'd3));
    add(mk(0,0,0, 12'h808,1,1,0,0,5'd0,16'd4));
    add(mk(0,0,0, 12'h040,1,1,0,0,5'd0,16'd5));
    add(mk(0,0,0, 12'h880,1,1,0,0,5'd0,16'd6));
    add(mk(0,0,0, 12'h880,0,0,1,0,5'd0,16'd6));
    // D: loop over two words, stop after five applied
    d_lo = n_rows;
    add(mk(1,0,0, 12'h880,0,0,0,0,5'd0,16'd6));
    add(mk(0,0,0, 12'h880,0,1,0,1,5'd0,16'd0));
    add(mk(0,0,0, 12'h880,0,1,0,1,5'd1,16'd0));
    add(mk(0,0,0, 12'h010,1,1,0,1,5'd0,16'd1));
    add(mk(0,0,0, 12'h020,1,1,0,1,5'd1,16'd2));
    add(mk(0,0,0, 12'h010,1,1,0,1,5'd0,16'd3));
    add(mk(0,0,0, 12'h020,1,1,0,1,5'd1,16'd4));
    add(mk(0,1,0, 12'h010,1,1,0,0,5'd0,16'd5));
    add(mk(0,0,0, 12'h000,0,0,0,0,5'd0,16'd5));
    add(mk(0,0,0, 12'h000,0,0,0,0,5'd0,16'd5));
    // E: single word; start beats stop in IDLE; second start while busy ignored
    e_lo = n_rows;
    add(mk(1,1,0, 12'h000,0,0,0,0,5'd0,16'd5));
    add(mk(0,0,0, 12'h000,0,1,0,1,5'd0,16'd0));
    add(mk(1,0,0, 12'h000,0,1,0,0,5'd0,16'd0));
    add(mk(0,0,0, 12'h7FF,1,1,0,0,5'd0,16'd1));
    add(mk(0,0,0, 12'h7FF,0,0,1,0,5'd0,16'd1));
    add(mk(0,0,0, 12'h7FF,0,0,0,0,5'd0,16'd1));

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outs(-1, mk(0,0,0, 12'h000,0,0,0,0,5'd0,16'd0));
    @(posedge clk);
    #1 rst = 1'b1;

    bus.loop = 1'b0; bus.last_addr = 5'd3;
    run_rows(a_lo, b_lo - 1);
    run_rows(b_lo, c_lo - 1);
    bus.last_addr = 5'd5;
    run_rows(c_lo, d_lo - 1);
    ram[0] = 12'h010; ram[1] = 12'h020;
    bus.loop = 1'b1; bus.last_addr = 5'd1;
    run_rows(d_lo, e_lo - 1);
    ram[0] = 12'h7FF;
    bus.loop = 1'b0; bus.last_addr = 5'd0;
    run_rows(e_lo, n_rows - 1);

    // Reset mid-run, then a fresh start must replay scenario A exactly
    load_ram_a();
    bus.loop = 1'b0; bus.last_addr = 5'd3;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check_outs(-2, mk(0,0,0, 12'h801,1,1,0,1,5'd2,16'd1));
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_outs(-3, mk(0,0,0, 12'h000,0,0,0,0,5'd0,16'd0));
    @(posedge clk);
    #1;
    run_rows(a_lo, b_lo - 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
